// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two engines, the arbiter and the SRAM port.
// The arbiter connects through the slave modport; the requester/SRAM side uses master.
interface sram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 1536
);
  logic              f_req;
  logic              f_wen;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic              f_ack;

  logic              a_req;
  logic              a_wen;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  f_req, f_wen, f_addr, f_wdata,
    input  a_req, a_wen, a_addr, a_wdata,
    input  read_data,
    output f_ack, a_ack, rdata, busy,
    output read_enable, write_enable, address, write_data
  );

  modport master (
    output f_req, f_wen, f_addr, f_wdata,
    output a_req, a_wen, a_addr, a_wdata,
    output read_data,
    input  f_ack, a_ack, rdata, busy,
    input  read_enable, write_enable, address, write_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin, one-transaction-at-a-time owner of the shared SRAM port for the
// fill and alpha-blend engines. ACC_CYC (1..15) sets how long strobes are held.
module sram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 1536,
  parameter int ACC_CYC = 2
) (
  input  logic           clk,
  input  logic           n_rst,
  sram_arbiter_if.slave  bus
);

  localparam int          CNT_W       = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FILL  = 1'b0,
    OWN_ALPHA = 1'b1
  } owner_t;

  state_t            r_state,        w_state;
  logic [CNT_W-1:0]  r_cnt,          w_cnt;
  owner_t            r_owner,        w_owner;
  owner_t            r_last_grant,   w_last_grant;
  logic              r_wen,          w_wen;
  logic [ADDR_W-1:0] r_address,      w_address;
  logic [DATA_W-1:0] r_write_data,   w_write_data;
  logic [DATA_W-1:0] r_rdata,        w_rdata;
  logic              r_read_en,      w_read_en;
  logic              r_write_en,     w_write_en;
  logic              r_f_ack,        w_f_ack;
  logic              r_a_ack,        w_a_ack;
  logic              r_busy,         w_busy;

  logic              w_req_any;
  logic              w_grant_alpha;

  // Alpha wins only when fill is idle or when fill owned the previous slot.
  assign w_req_any     = bus.f_req | bus.a_req;
  assign w_grant_alpha = bus.a_req & (~bus.f_req | (r_last_grant == OWN_FILL));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_owner      <= OWN_FILL;
      r_last_grant <= OWN_ALPHA;
      r_wen        <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_rdata      <= '0;
      r_read_en    <= 1'b0;
      r_write_en   <= 1'b0;
      r_f_ack      <= 1'b0;
      r_a_ack      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_owner      <= w_owner;
      r_last_grant <= w_last_grant;
      r_wen        <= w_wen;
      r_address    <= w_address;
      r_write_data <= w_write_data;
      r_rdata      <= w_rdata;
      r_read_en    <= w_read_en;
      r_write_en   <= w_write_en;
      r_f_ack      <= w_f_ack;
      r_a_ack      <= w_a_ack;
      r_busy       <= w_busy;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_owner      = r_owner;
    w_last_grant = r_last_grant;
    w_wen        = r_wen;
    w_address    = r_address;
    w_write_data = r_write_data;
    w_rdata      = r_rdata;
    w_read_en    = 1'b0;
    w_write_en   = 1'b0;
    w_f_ack      = 1'b0;
    w_a_ack      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_state = ST_ACCESS;
          w_cnt   = CNT_INIT;
          if (w_grant_alpha) begin
            w_owner      = OWN_ALPHA;
            w_wen        = bus.a_wen;
            w_address    = bus.a_addr;
            w_write_data = bus.a_wdata;
          end else begin
            w_owner      = OWN_FILL;
            w_wen        = bus.f_wen;
            w_address    = bus.f_addr;
            w_write_data = bus.f_wdata;
          end
          w_read_en  = ~w_wen;
          w_write_en = w_wen;
        end
      end

      ST_ACCESS: begin
        if (r_cnt == '0) begin
          // Last strobe cycle: capture read data and schedule the owner's ack.
          if (!r_wen) begin
            w_rdata = bus.read_data;
          end
          w_state = ST_DONE;
          w_f_ack = (r_owner == OWN_FILL);
          w_a_ack = (r_owner == OWN_ALPHA);
        end else begin
          w_cnt      = r_cnt - 1'b1;
          w_read_en  = r_read_en;
          w_write_en = r_write_en;
        end
      end

      ST_DONE: begin
        w_last_grant = r_owner;
        w_state      = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  assign bus.f_ack        = r_f_ack;
  assign bus.a_ack        = r_a_ack;
  assign bus.rdata        = r_rdata;
  assign bus.busy         = r_busy;
  assign bus.read_enable  = r_read_en;
  assign bus.write_enable = r_write_en;
  assign bus.address      = r_address;
  assign bus.write_data   = r_write_data;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!n_rst)
    !(r_read_en && r_write_en));
  a_strobe_state: assert property (@(posedge clk) disable iff (!n_rst)
    (r_read_en || r_write_en) |-> (r_state == ST_ACCESS));
  a_ack_excl: assert property (@(posedge clk) disable iff (!n_rst)
    !(r_f_ack && r_a_ack));

endmodule
